// File: rtl/ad5791_pkg.sv
// Shared constants, frame layout and FSM encoding for the AD5791 serial DAC controller.
package ad5791_pkg;

  localparam int FRAME_NBIT = 24;

  localparam logic [2:0] ADDR_DAC  = 3'b001;
  localparam logic [2:0] ADDR_CTRL = 3'b010;

  // RBUF=1, offset binary, SDO disabled, output neither grounded nor tristated
  localparam logic [FRAME_NBIT-1:0] CTRL_INIT_DEF = {1'b0, ADDR_CTRL, 20'h00032};

  typedef enum logic [2:0] {
    ST_INIT_WAIT = 3'd0,
    ST_INIT_TX   = 3'd1,
    ST_GAP       = 3'd2,
    ST_IDLE      = 3'd3,
    ST_TX        = 3'd4
  } state_e;

endpackage

// File: rtl/ad5791_txfifo.sv
// Small synchronous TX FIFO: registered count, combinational head read.
module ad5791_txfifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
      if (push_i && !pop_i)      count_q <= count_q + 1'b1;
      else if (pop_i && !push_i) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/ad5791_ctrl.sv
// AD5791 controller: control-register write after reset, then one DAC write frame per dac_start.
module ad5791_ctrl
  import ad5791_pkg::*;
#(
  parameter int                    DATA_NBIT  = 20,
  parameter int                    FIFO_DEPTH = 4,
  parameter int                    SCLK_HALF  = 2,
  parameter int                    INIT_DLY   = 16,
  parameter logic [FRAME_NBIT-1:0] CTRL_INIT  = CTRL_INIT_DEF
) (
  input  logic                 mclk,
  input  logic                 rst,
  input  logic                 dac_start,
  input  logic                 dac_dv,
  input  logic [DATA_NBIT-1:0] dac_data,
  output logic                 dac_waitrequest,
  output logic                 dac_sync_n,
  output logic                 dac_sclk,
  output logic                 dac_sdin,
  output logic                 dac_ldac_n,
  output logic                 dac_underrun,
  output logic                 dac_collision
);

  localparam int             CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0]    INIT_LAST = 16'(INIT_DLY - 1);
  localparam logic [15:0]    HALF_LAST = 16'(SCLK_HALF - 1);
  localparam logic [15:0]    GAP_LAST  = 16'(2*SCLK_HALF - 1);
  localparam logic [5:0]     HALF_END  = 6'(2*FRAME_NBIT);

  state_e                state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [5:0]            half_q, half_d;
  logic [FRAME_NBIT-1:0] sreg_q, sreg_d;
  logic                  sync_q, sync_d, sclk_q, sclk_d, sdin_q, sdin_d, ldac_q, ldac_d;
  logic                  underrun_q, underrun_d, collision_q, collision_d;
  logic                  load, pop, push, fifo_full, fifo_empty;
  logic [FRAME_NBIT-1:0] load_frame;
  logic [DATA_NBIT-1:0]  fifo_head;
  logic [CNT_W-1:0]      fifo_count;

  assign push = dac_dv && !fifo_full;

  ad5791_txfifo #(.WIDTH(DATA_NBIT), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (mclk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (dac_data),
    .rdata_o (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    half_d      = half_q;
    sreg_d      = sreg_q;
    sync_d      = sync_q;
    sclk_d      = sclk_q;
    sdin_d      = sdin_q;
    ldac_d      = ldac_q;
    underrun_d  = 1'b0;
    collision_d = 1'b0;
    pop         = 1'b0;
    load        = 1'b0;
    load_frame  = CTRL_INIT;
    case (state_q)
      ST_INIT_WAIT: begin
        collision_d = dac_start;
        if (cnt_q == INIT_LAST) begin
          load    = 1'b1;
          state_d = ST_INIT_TX;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_IDLE: begin
        if (dac_start) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            load       = 1'b1;
            load_frame = {1'b0, ADDR_DAC, fifo_head};
            state_d    = ST_TX;
          end else begin
            underrun_d = 1'b1;
          end
        end
      end
      ST_INIT_TX, ST_TX: begin
        collision_d = dac_start;
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (half_q == HALF_END) begin
            state_d = ST_GAP;
            sync_d  = 1'b1;
            sclk_d  = 1'b1;
            sdin_d  = 1'b0;
            if (state_q == ST_INIT_TX) ldac_d = 1'b0;
          end else begin
            half_d = half_q + 6'd1;
            // Odd half ends: SCLK rises and the next bit is presented
            sclk_d = half_q[0];
            if (half_q[0]) begin
              sreg_d = sreg_q << 1;
              sdin_d = sreg_d[FRAME_NBIT-1];
            end
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_GAP: begin
        collision_d = dac_start;
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = ST_INIT_WAIT;
    endcase
    if (load) begin
      sreg_d = load_frame;
      sdin_d = load_frame[FRAME_NBIT-1];
      sync_d = 1'b0;
      sclk_d = 1'b1;
      cnt_d  = '0;
      half_d = '0;
    end
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      state_q     <= ST_INIT_WAIT;
      cnt_q       <= '0;
      half_q      <= '0;
      sync_q      <= 1'b1;
      sclk_q      <= 1'b1;
      sdin_q      <= 1'b0;
      ldac_q      <= 1'b1;
      underrun_q  <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      half_q      <= half_d;
      sync_q      <= sync_d;
      sclk_q      <= sclk_d;
      sdin_q      <= sdin_d;
      ldac_q      <= ldac_d;
      underrun_q  <= underrun_d;
      collision_q <= collision_d;
    end
  end

  always_ff @(posedge mclk) begin
    sreg_q <= sreg_d;
  end

  assign dac_waitrequest = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign dac_sync_n      = sync_q;
  assign dac_sclk        = sclk_q;
  assign dac_sdin        = sdin_q;
  assign dac_ldac_n      = ldac_q;
  assign dac_underrun    = underrun_q;
  assign dac_collision   = collision_q;

endmodule

// File: tb/tb_ad5791_ctrl.sv
// Directed bench for ad5791_ctrl: decodes SPI frames at SCLK falls and checks FIFO/FSM behaviour.
module tb_ad5791_ctrl;

  logic        mclk = 1'b0;
  logic        rst = 1'b1;
  logic        dac_start = 1'b0;
  logic        dac_dv = 1'b0;
  logic [19:0] dac_data = '0;
  logic        dac_waitrequest, dac_sync_n, dac_sclk, dac_sdin, dac_ldac_n;
  logic        dac_underrun, dac_collision;

  int checks = 0;
  int errors = 0;

  // Frame monitor state
  int          frames_seen = 0;
  logic [23:0] mon_sh = '0;
  int          mon_bits = 0;
  int          mon_low = 0;
  logic        mon_prev_sync = 1'b1;
  logic        mon_prev_sclk = 1'b1;
  logic [23:0] last_frame = '0;
  int          last_bits = 0;
  int          last_low = 0;
  logic        last_ldac_end = 1'b1;
  logic        last_ldac_start = 1'b0;
  logic        cur_ldac_start = 1'b0;

  ad5791_ctrl dut (
    .mclk            (mclk),
    .rst             (rst),
    .dac_start       (dac_start),
    .dac_dv          (dac_dv),
    .dac_data        (dac_data),
    .dac_waitrequest (dac_waitrequest),
    .dac_sync_n      (dac_sync_n),
    .dac_sclk        (dac_sclk),
    .dac_sdin        (dac_sdin),
    .dac_ldac_n      (dac_ldac_n),
    .dac_underrun    (dac_underrun),
    .dac_collision   (dac_collision)
  );

  always #5 mclk = ~mclk;

  always @(negedge mclk) begin
    if (rst) begin
      mon_prev_sync = 1'b1;
      mon_prev_sclk = 1'b1;
      mon_bits = 0;
      mon_low = 0;
    end else begin
      if (!dac_sync_n) begin
        if (mon_prev_sync) begin
          mon_bits = 0;
          mon_low = 0;
          cur_ldac_start = dac_ldac_n;
        end
        mon_low++;
        if (mon_prev_sclk && !dac_sclk) begin
          mon_sh = {mon_sh[22:0], dac_sdin};
          mon_bits++;
        end
      end else if (!mon_prev_sync) begin
        last_frame = mon_sh;
        last_bits = mon_bits;
        last_low = mon_low;
        last_ldac_end = dac_ldac_n;
        last_ldac_start = cur_ldac_start;
        frames_seen++;
      end
      mon_prev_sync = dac_sync_n;
      mon_prev_sclk = dac_sclk;
    end
  end

  task automatic step();
    @(negedge mclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_frame(input string tag);
    int n;
    n = frames_seen;
    for (int i = 0; i < 400; i++) begin
      step();
      if (frames_seen != n) break;
    end
    check({tag, "_seen"}, 32'(frames_seen != n), 32'd1);
  endtask

  task automatic settle();
    for (int i = 0; i < 5; i++) step();
  endtask

  task automatic push(input logic [19:0] d);
    dac_dv = 1'b1;
    dac_data = d;
    step();
    dac_dv = 1'b0;
  endtask

  task automatic start_frame();
    dac_start = 1'b1;
    step();
    dac_start = 1'b0;
  endtask

  task automatic expect_frame(input string tag, input logic [23:0] f);
    wait_frame(tag);
    check({tag, "_data"}, 32'(last_frame), 32'(f));
    check({tag, "_bits"}, 32'(last_bits), 32'd24);
    settle();
  endtask

  task automatic init_sequence(input string tag);
    int n;
    rst = 1'b0;
    dac_start = 1'b1;
    step();
    dac_start = 1'b0;
    check({tag, "_init_collision"}, 32'(dac_collision), 32'd1);
    n = 1;
    while (dac_sync_n && n < 100) begin
      step();
      n++;
    end
    check({tag, "_init_delay"}, 32'(n), 32'd16);
    wait_frame({tag, "_ctrl"});
    check({tag, "_ctrl_data"}, 32'(last_frame), 32'h200032);
    check({tag, "_ctrl_low"}, 32'(last_low), 32'd98);
    check({tag, "_ldac_during"}, 32'(last_ldac_start), 32'd1);
    check({tag, "_ldac_after"}, 32'(last_ldac_end), 32'd0);
    settle();
  endtask

  initial begin
    // Reset values
    step();
    step();
    check("rst_sync", 32'(dac_sync_n), 32'd1);
    check("rst_sclk", 32'(dac_sclk), 32'd1);
    check("rst_sdin", 32'(dac_sdin), 32'd0);
    check("rst_ldac", 32'(dac_ldac_n), 32'd1);
    check("rst_wait", 32'(dac_waitrequest), 32'd0);
    check("rst_under", 32'(dac_underrun), 32'd0);
    check("rst_coll", 32'(dac_collision), 32'd0);

    init_sequence("boot");

    // Single sample frame
    push(20'h80000);
    check("one_wait", 32'(dac_waitrequest), 32'd0);
    start_frame();
    check("one_sync_first", 32'(dac_sync_n), 32'd0);
    check("one_sdin_first", 32'(dac_sdin), 32'd0);
    wait_frame("one");
    check("one_data", 32'(last_frame), 32'h180000);
    check("one_low", 32'(last_low), 32'd98);
    check("one_ldac", 32'(dac_ldac_n), 32'd0);
    settle();
    start_frame();
    check("one_empty_under", 32'(dac_underrun), 32'd1);
    check("one_empty_sync", 32'(dac_sync_n), 32'd1);
    step();
    check("under_pulse_end", 32'(dac_underrun), 32'd0);

    // Fill past full
    push(20'h12345);
    push(20'hABCDE);
    push(20'hFFFFF);
    check("fill3_wait", 32'(dac_waitrequest), 32'd0);
    push(20'h00001);
    check("fill4_wait", 32'(dac_waitrequest), 32'd1);
    push(20'h55555);
    check("fill5_wait", 32'(dac_waitrequest), 32'd1);
    start_frame();
    check("drain1_wait", 32'(dac_waitrequest), 32'd0);
    expect_frame("drain1", 24'h112345);
    start_frame();
    expect_frame("drain2", 24'h1ABCDE);
    start_frame();
    expect_frame("drain3", 24'h1FFFFF);
    start_frame();
    expect_frame("drain4", 24'h100001);
    start_frame();
    check("drain5_under", 32'(dac_underrun), 32'd1);

    // Collisions mid-frame and in the gap
    step();
    push(20'h3C3C3);
    start_frame();
    for (int i = 0; i < 20; i++) step();
    start_frame();
    check("coll_mid", 32'(dac_collision), 32'd1);
    check("coll_mid_sync", 32'(dac_sync_n), 32'd0);
    wait_frame("coll");
    check("coll_data", 32'(last_frame), 32'h13C3C3);
    check("coll_bits", 32'(last_bits), 32'd24);
    start_frame();
    check("coll_gap", 32'(dac_collision), 32'd1);
    check("coll_gap_under", 32'(dac_underrun), 32'd0);
    settle();
    start_frame();
    check("coll_after_under", 32'(dac_underrun), 32'd1);

    // Simultaneous push and pop at full and at count 2
    step();
    push(20'h0000A);
    push(20'h0000B);
    push(20'h0000C);
    push(20'h0000D);
    check("sim_full", 32'(dac_waitrequest), 32'd1);
    dac_dv = 1'b1;
    dac_data = 20'h0000E;
    dac_start = 1'b1;
    step();
    dac_dv = 1'b0;
    dac_start = 1'b0;
    check("sim_full_pop", 32'(dac_waitrequest), 32'd0);
    expect_frame("simA", 24'h10000A);
    start_frame();
    expect_frame("simB", 24'h10000B);
    dac_dv = 1'b1;
    dac_data = 20'h0000F;
    dac_start = 1'b1;
    step();
    dac_dv = 1'b0;
    dac_start = 1'b0;
    check("sim2_wait", 32'(dac_waitrequest), 32'd0);
    expect_frame("simC", 24'h10000C);
    start_frame();
    expect_frame("simD", 24'h10000D);
    start_frame();
    expect_frame("simF", 24'h10000F);
    start_frame();
    check("sim_end_under", 32'(dac_underrun), 32'd1);

    // Reset in the middle of a frame
    step();
    push(20'h77777);
    push(20'h66666);
    start_frame();
    for (int i = 0; i < 40; i++) step();
    rst = 1'b1;
    step();
    check("mid_rst_sync", 32'(dac_sync_n), 32'd1);
    check("mid_rst_sclk", 32'(dac_sclk), 32'd1);
    check("mid_rst_ldac", 32'(dac_ldac_n), 32'd1);
    check("mid_rst_wait", 32'(dac_waitrequest), 32'd0);
    step();
    init_sequence("reboot");
    start_frame();
    check("reboot_flushed", 32'(dac_underrun), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
